// File: rtl/sad_pkg.sv
// Shared definitions for the row-parallel SAD accumulator.
//   sad_w()   : width of a block SAD for the given geometry
//   DEF_*     : default geometry (8-bit pixels, 16 columns, 16x16 block)
//   pixel_t   : one pixel at the default width
package sad_pkg;

  localparam int unsigned DEF_PIXEL_W   = 8;
  localparam int unsigned DEF_COLS      = 16;
  localparam int unsigned DEF_MACRO_DIM = 16;
  localparam int unsigned DEF_CAND_W    = 10;

  typedef logic [DEF_PIXEL_W-1:0] pixel_t;

  // Wide enough for COLS*MACRO_DIM*(2^PIXEL_W - 1), so accumulation never wraps.
  function automatic int unsigned sad_w(input int unsigned pixel_w,
                                        input int unsigned cols,
                                        input int unsigned macro_dim);
    return pixel_w + $clog2(cols * macro_dim);
  endfunction

endpackage

// File: rtl/sad_row_acc_if.sv
// Row/result bundle between the pixel row buffers and the SAD accumulator.
//   master : row-buffer side (drives clear, in_valid, both pixel rows)
//   slave  : accumulator side (drives block SAD and best-candidate results)
interface sad_row_acc_if
  import sad_pkg::*;
#(
  parameter int unsigned PIXEL_W   = DEF_PIXEL_W,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned MACRO_DIM = DEF_MACRO_DIM,
  parameter int unsigned CAND_W    = DEF_CAND_W
);
  localparam int unsigned SAD_W = sad_w(PIXEL_W, COLS, MACRO_DIM);

  logic                    clear;
  logic                    in_valid;
  logic [COLS*PIXEL_W-1:0] pixel_spr_in;
  logic [COLS*PIXEL_W-1:0] pixel_cpr_in;
  logic [SAD_W-1:0]        sad_out;
  logic                    sad_valid;
  logic [CAND_W-1:0]       sad_idx;
  logic [SAD_W-1:0]        best_sad;
  logic [CAND_W-1:0]       best_idx;
  logic                    best_valid;

  modport master (
    output clear, in_valid, pixel_spr_in, pixel_cpr_in,
    input  sad_out, sad_valid, sad_idx, best_sad, best_idx, best_valid
  );

  modport slave (
    input  clear, in_valid, pixel_spr_in, pixel_cpr_in,
    output sad_out, sad_valid, sad_idx, best_sad, best_idx, best_valid
  );

endinterface

// File: rtl/sad_cell.sv
// One column of the SAD array: stage-0 pixel registers plus |spr - cpr|.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : synchronous flush (row presented with clear is not loaded)
//   i_valid    : load i_spr/i_cpr this cycle
//   i_spr/i_cpr: search / current pixel for this column
//   o_absdiff  : absolute difference of the registered pixels
module sad_cell #(
  parameter int unsigned PIXEL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [PIXEL_W-1:0] i_spr,
  input  logic [PIXEL_W-1:0] i_cpr,
  output logic [PIXEL_W-1:0] o_absdiff
);

  logic [PIXEL_W-1:0] r_spr;
  logic [PIXEL_W-1:0] r_cpr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spr <= '0;
      r_cpr <= '0;
    end else if (i_valid && !i_clear) begin
      r_spr <= i_spr;
      r_cpr <= i_cpr;
    end
  end

  // Compare-then-subtract keeps the result unsigned at PIXEL_W bits.
  always_comb begin
    if (r_spr >= r_cpr) o_absdiff = r_spr - r_cpr;
    else                o_absdiff = r_cpr - r_spr;
  end

endmodule

// File: rtl/sad_row_acc.sv
// Row-parallel motion-estimation SAD accumulator.
// Stage 0: per-column pixel registers (sad_cell), Stage 1: registered row
// sum, Stage 2: block accumulation, candidate counting and best tracking.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of sad_row_acc_if (rows in, block results out)
module sad_row_acc
  import sad_pkg::*;
#(
  parameter int unsigned PIXEL_W   = DEF_PIXEL_W,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned MACRO_DIM = DEF_MACRO_DIM,
  parameter int unsigned CAND_W    = DEF_CAND_W
) (
  input  logic          clk,
  input  logic          rst_n,
  sad_row_acc_if.slave  bus
);

  localparam int unsigned SAD_W = sad_w(PIXEL_W, COLS, MACRO_DIM);
  localparam int unsigned ROW_W = PIXEL_W + $clog2(COLS);
  localparam int unsigned CNT_W = (MACRO_DIM > 1) ? $clog2(MACRO_DIM) : 1;

  logic               r_v0;
  logic               r_v1;
  logic [PIXEL_W-1:0] w_diff [COLS];
  logic [ROW_W-1:0]   w_row_sum;
  logic [ROW_W-1:0]   r_row_sum;
  logic [CNT_W-1:0]   r_row_cnt;
  logic [SAD_W-1:0]   r_acc;
  logic [CAND_W-1:0]  r_cand;
  logic [SAD_W-1:0]   r_sad_out;
  logic               r_sad_valid;
  logic [CAND_W-1:0]  r_sad_idx;
  logic [SAD_W-1:0]   r_best_sad;
  logic [CAND_W-1:0]  r_best_idx;
  logic               r_best_valid;
  logic [SAD_W-1:0]   w_block_sad;
  logic               w_last_row;

  for (genvar c = 0; c < COLS; c++) begin : g_cell
    sad_cell #(.PIXEL_W(PIXEL_W)) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (bus.clear),
      .i_valid   (bus.in_valid),
      .i_spr     (bus.pixel_spr_in[c*PIXEL_W +: PIXEL_W]),
      .i_cpr     (bus.pixel_cpr_in[c*PIXEL_W +: PIXEL_W]),
      .o_absdiff (w_diff[c])
    );
  end

  always_comb begin
    w_row_sum = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      w_row_sum = w_row_sum + ROW_W'(w_diff[i]);
    end
  end

  // Stage 0/1 valid pipeline and registered row sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_row_sum <= '0;
    end else if (bus.clear) begin
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_row_sum <= '0;
    end else begin
      r_v0      <= bus.in_valid;
      r_v1      <= r_v0;
      r_row_sum <= w_row_sum;
    end
  end

  assign w_block_sad = r_acc + SAD_W'(r_row_sum);
  assign w_last_row  = (r_row_cnt == CNT_W'(MACRO_DIM - 1));

  // Stage 2: block accumulation, result register and best tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt    <= '0;
      r_acc        <= '0;
      r_cand       <= '0;
      r_sad_out    <= '0;
      r_sad_valid  <= 1'b0;
      r_sad_idx    <= '0;
      r_best_sad   <= '1;
      r_best_idx   <= '0;
      r_best_valid <= 1'b0;
    end else if (bus.clear) begin
      r_row_cnt    <= '0;
      r_acc        <= '0;
      r_cand       <= '0;
      r_sad_valid  <= 1'b0;
      r_best_sad   <= '1;
      r_best_idx   <= '0;
      r_best_valid <= 1'b0;
    end else begin
      r_sad_valid <= 1'b0;
      if (r_v1) begin
        if (w_last_row) begin
          r_sad_out   <= w_block_sad;
          r_sad_idx   <= r_cand;
          r_sad_valid <= 1'b1;
          r_acc       <= '0;
          r_row_cnt   <= '0;
          r_cand      <= r_cand + CAND_W'(1);
          // Strict compare: a tie keeps the earlier candidate.
          if (!r_best_valid || (w_block_sad < r_best_sad)) begin
            r_best_sad   <= w_block_sad;
            r_best_idx   <= r_cand;
            r_best_valid <= 1'b1;
          end
        end else begin
          r_acc     <= w_block_sad;
          r_row_cnt <= r_row_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.sad_out    = r_sad_out;
  assign bus.sad_valid  = r_sad_valid;
  assign bus.sad_idx    = r_sad_idx;
  assign bus.best_sad   = r_best_sad;
  assign bus.best_idx   = r_best_idx;
  assign bus.best_valid = r_best_valid;

endmodule

// File: tb/tb_sad_row_acc.sv
// Scoreboard bench for sad_row_acc: the row driver models each block and
// pushes the expected result (value, index, arrival cycle, best state);
// a negedge monitor collects every sad_valid pulse for comparison.
module tb_sad_row_acc;
  import sad_pkg::*;

  localparam int unsigned PW = 8;
  localparam int unsigned NC = 16;
  localparam int unsigned MD = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned SW = sad_w(PW, NC, MD);
  localparam int unsigned RW = NC * PW;

  typedef logic [RW-1:0] row_t;
  typedef struct packed {
    logic [SW-1:0] sad;
    logic [CW-1:0] idx;
    logic [31:0]   cyc;
    logic [SW-1:0] bsad;
    logic [CW-1:0] bidx;
    logic          bval;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sad_row_acc_if #(.PIXEL_W(PW), .COLS(NC), .MACRO_DIM(MD), .CAND_W(CW)) bus ();

  sad_row_acc #(.PIXEL_W(PW), .COLS(NC), .MACRO_DIM(MD), .CAND_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  ent_t        exp_q[$];
  ent_t        obs_q[$];

  int          m_rows, m_acc, m_cand, m_bsad, m_bidx;
  bit          m_bval;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.sad_valid)
      obs_q.push_back({bus.sad_out, bus.sad_idx, 32'(cyc),
                       bus.best_sad, bus.best_idx, bus.best_valid});
  end

  task automatic model_reset();
    m_rows = 0; m_acc = 0; m_cand = 0;
    m_bsad = (1 << SW) - 1; m_bidx = 0; m_bval = 0;
  endtask

  // Drives one cycle of inputs at the negedge and advances the block model.
  task automatic drive(input row_t s, input row_t c, input bit v, input bit clr);
    int a, b, rs;
    ent_t e;
    @(negedge clk);
    bus.pixel_spr_in = s;
    bus.pixel_cpr_in = c;
    bus.in_valid     = v;
    bus.clear        = clr;
    if (clr) model_reset();
    else if (v) begin
      rs = 0;
      for (int i = 0; i < int'(NC); i++) begin
        a = int'(s[i*PW +: PW]);
        b = int'(c[i*PW +: PW]);
        rs += (a > b) ? a - b : b - a;
      end
      m_acc += rs;
      if (m_rows == MD - 1) begin
        if (!m_bval || m_acc < m_bsad) begin
          m_bsad = m_acc; m_bidx = m_cand; m_bval = 1;
        end
        e.sad = SW'(m_acc); e.idx = CW'(m_cand); e.cyc = cyc + 3;
        e.bsad = SW'(m_bsad); e.bidx = CW'(m_bidx); e.bval = m_bval;
        exp_q.push_back(e);
        m_acc = 0; m_rows = 0; m_cand = (m_cand + 1) % (1 << CW);
      end else m_rows++;
    end
  endtask

  // Idles the inputs until every expected block has shown up (bounded),
  // plus a few extra cycles so a held or spurious pulse is also caught.
  task automatic drain();
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 60) begin
      drive('0, '0, 0, 0); t++;
    end
    repeat (4) drive('0, '0, 0, 0);
  endtask

  function automatic row_t rnd_row();
    row_t r;
    for (int i = 0; i < int'(NC); i++) r[i*PW +: PW] = PW'($urandom_range(255));
    return r;
  endfunction

  task automatic mk_diff(input int d, output row_t s, output row_t c);
    int p;
    for (int i = 0; i < int'(NC); i++) begin
      p = $urandom_range(255, d);
      s[i*PW +: PW] = PW'(p);
      c[i*PW +: PW] = PW'(p - d);
    end
  endtask

  task automatic test_reset();
    bus.clear = 0; bus.in_valid = 0; bus.pixel_spr_in = '0; bus.pixel_cpr_in = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.sad_out, bus.sad_valid, bus.sad_idx, bus.best_sad, bus.best_idx, bus.best_valid}
        !== {SW'(0), 1'b0, CW'(0), {SW{1'b1}}, CW'(0), 1'b0}) begin
      fails++;
      $display("FAIL reset: got sad=%0d v=%0b idx=%0d best=%0d/%0d/%0b exp 0/0/0 best=%0d/0/0",
               bus.sad_out, bus.sad_valid, bus.sad_idx, bus.best_sad, bus.best_idx,
               bus.best_valid, (1 << SW) - 1);
    end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_equal();
    row_t s; ent_t e, o;
    for (int r = 0; r < int'(MD); r++) begin s = rnd_row(); drive(s, s, 1, 0); end
    drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL equal count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e || e.sad != 0 || e.bval != 1) begin
        fails++;
        $display("FAIL equal blk: got %0d/%0d@%0d best %0d/%0d/%0b exp %0d/%0d@%0d best %0d/%0d/%0b",
                 o.sad, o.idx, o.cyc, o.bsad, o.bidx, o.bval, e.sad, e.idx, e.cyc, e.bsad, e.bidx, e.bval);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_maxdiff();
    row_t hi, lo; ent_t e, o;
    hi = '1; lo = '0;
    drive('0, '0, 0, 1);
    for (int r = 0; r < int'(MD); r++) drive(hi, lo, 1, 0);
    for (int r = 0; r < int'(MD); r++) drive(lo, hi, 1, 0);
    drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL maxdiff count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e || e.sad != 65280) begin
        fails++;
        $display("FAIL maxdiff blk: got %0d/%0d@%0d best %0d/%0d/%0b exp %0d/%0d@%0d best %0d/%0d/%0b",
                 o.sad, o.idx, o.cyc, o.bsad, o.bidx, o.bval, e.sad, e.idx, e.cyc, e.bsad, e.bidx, e.bval);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    row_t s, c; ent_t e, o;
    int diffs[3] = '{3, 1, 1};
    drive('0, '0, 0, 1);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < int'(MD); r++) begin mk_diff(diffs[k], s, c); drive(s, c, 1, 0); end
    drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b blk: got %0d/%0d@%0d best %0d/%0d/%0b exp %0d/%0d@%0d best %0d/%0d/%0b",
                 o.sad, o.idx, o.cyc, o.bsad, o.bidx, o.bval, e.sad, e.idx, e.cyc, e.bsad, e.bidx, e.bval);
      end
    end
    exp_q.delete(); obs_q.delete();
    tests++;
    if (bus.best_sad !== SW'(256) || bus.best_idx !== CW'(1)) begin
      fails++; $display("FAIL b2b best: got %0d/%0d exp 256/1", bus.best_sad, bus.best_idx);
    end
  endtask

  task automatic test_random_gaps();
    ent_t e, o;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < int'(MD); r++) begin
        repeat ($urandom_range(2)) drive(rnd_row(), rnd_row(), 0, 0);
        drive(rnd_row(), rnd_row(), 1, 0);
      end
    drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL gaps count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL gaps blk: got %0d/%0d@%0d best %0d/%0d/%0b exp %0d/%0d@%0d best %0d/%0d/%0b",
                 o.sad, o.idx, o.cyc, o.bsad, o.bidx, o.bval, e.sad, e.idx, e.cyc, e.bsad, e.bidx, e.bval);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clear();
    ent_t e, o;
    for (int r = 0; r < 7; r++) drive(rnd_row(), rnd_row(), 1, 0);
    drive(rnd_row(), rnd_row(), 1, 1);
    for (int r = 0; r < int'(MD); r++) begin
      drive(rnd_row(), rnd_row(), 1, 0);
      tests++;
      if (bus.best_valid !== 1'b0) begin
        fails++; $display("FAIL clear best_valid row%0d: got %0b exp 0", r, bus.best_valid);
      end
    end
    drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL clear count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e || e.idx != 0) begin
        fails++;
        $display("FAIL clear blk: got %0d/%0d@%0d best %0d/%0d/%0b exp %0d/%0d@%0d best %0d/%0d/%0b",
                 o.sad, o.idx, o.cyc, o.bsad, o.bidx, o.bval, e.sad, e.idx, e.cyc, e.bsad, e.bidx, e.bval);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_rst_mid();
    ent_t e, o;
    for (int r = 0; r < 6; r++) drive(rnd_row(), rnd_row(), 1, 0);
    @(negedge clk);
    bus.in_valid = 0;
    rst_n = 0;
    #1;
    tests++;
    if ({bus.sad_out, bus.sad_valid, bus.sad_idx, bus.best_sad, bus.best_idx, bus.best_valid}
        !== {SW'(0), 1'b0, CW'(0), {SW{1'b1}}, CW'(0), 1'b0}) begin
      fails++;
      $display("FAIL rst_mid outputs: got sad=%0d v=%0b idx=%0d best=%0d/%0d/%0b exp 0/0/0 best=%0d/0/0",
               bus.sad_out, bus.sad_valid, bus.sad_idx, bus.best_sad, bus.best_idx,
               bus.best_valid, (1 << SW) - 1);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int r = 0; r < int'(MD); r++) drive(rnd_row(), rnd_row(), 1, 0);
    drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rst_mid count: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e || e.idx != 0) begin
        fails++;
        $display("FAIL rst_mid blk: got %0d/%0d@%0d best %0d/%0d/%0b exp %0d/%0d@%0d best %0d/%0d/%0b",
                 o.sad, o.idx, o.cyc, o.bsad, o.bidx, o.bval, e.sad, e.idx, e.cyc, e.bsad, e.bidx, e.bval);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_maxdiff();
    test_back_to_back();
    test_random_gaps();
    test_clear();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sad_row_acc.md
# sad_row_acc

Parametrised successor to the single-pixel motion-estimation processing element. It takes one full row of COLS search/current pixel pairs per cycle, forms per-column absolute differences, and reduces them through a pipelined sum. It accumulates MACRO_DIM rows into a block SAD per candidate and tracks the minimum SAD and its candidate index until cleared. It sits between the search/current pixel row buffers and the inter-prediction motion-vector decision logic.

## Interface
- PIXEL_W, 8, pixel bit width
- COLS, 16, pixel columns per row (number of absolute-difference cells)
- MACRO_DIM, 16, rows per block (rows accumulated per SAD)
- CAND_W, 10, candidate index width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of pipeline, row counter, accumulator and best tracker
- in_valid  in  1  row present on pixel inputs this cycle
- pixel_spr_in  in  COLS*PIXEL_W  search-window row; column c at bits [c*PIXEL_W +: PIXEL_W]
- pixel_cpr_in  in  COLS*PIXEL_W  current-macroblock row, same packing
- sad_out  out  SAD_W  block SAD, SAD_W = PIXEL_W + clog2(COLS*MACRO_DIM)
- sad_valid  out  1  one-cycle pulse, sad_out valid
- sad_idx  out  CAND_W  candidate index of sad_out
- best_sad  out  SAD_W  minimum SAD since reset/clear
- best_idx  out  CAND_W  candidate index of best_sad
- best_valid  out  1  at least one block completed since reset/clear

## Operation
- Stage 0: on in_valid, both pixel rows are registered; v0 <= in_valid. Pixel registers hold their value when in_valid = 0.
- Stage 1: per column, |spr - cpr| computed on the stage-0 registers using compare-then-subtract, unsigned, PIXEL_W result. The COLS values are summed into row_sum (width PIXEL_W + clog2(COLS)) and registered; v1 <= v0.
- Stage 2, when v1 = 1:
  - row_cnt < MACRO_DIM-1: acc <= acc + row_sum; row_cnt++.
  - row_cnt = MACRO_DIM-1: sad_out <= acc + row_sum; sad_idx <= cand_cnt; sad_valid <= 1; acc <= 0; row_cnt <= 0; cand_cnt++.
- cand_cnt wraps modulo 2^CAND_W. The first block after reset/clear is candidate 0.
- Best tracker updates on the same edge as sad_out if the new SAD < best_sad (strict), or if best_valid = 0. It then sets best_sad, best_idx and best_valid. Ties keep the earlier candidate.
- Gaps (in_valid = 0) between rows or blocks are allowed anywhere. Rows are counted only when valid.
- No overflow is possible: SAD_W covers COLS*MACRO_DIM*(2^PIXEL_W - 1).
- clear zeroes the following on the next edge: v0, v1, row_cnt, acc, cand_cnt, sad_valid and best_valid; best_sad is set to all-ones and best_idx to 0. A row presented with clear is dropped (clear wins). In-flight rows are discarded.
- Reset values: sad_out 0, sad_valid 0, sad_idx 0, best_sad all-ones, best_idx 0, best_valid 0, pixel registers 0. An asynchronous reset mid-block discards the partial block.

## Timing
- Last row of a block sampled at edge T: sad_out, sad_idx and the best_* update are visible after edge T+2. sad_valid is high for exactly one cycle after edge T+2.
- Throughput: one row per cycle. Blocks may be back-to-back; the last row of block k and the first row of block k+1 are on consecutive edges with no bubble.
- sad_valid is asserted for one cycle per block and never held.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package sad_pkg: function sad_w(pixel_w, cols, macro_dim), default parameter constants, and typedef pixel_t.
- Sub-module sad_cell: per-column stage-0 registers plus the absolute difference; instantiated COLS times by generate.
- Sum reduction: a single registered adder stage in the top level.
- Counters and the best tracker live in the top level.

## Test plan
- Equal rows: spr = cpr for 16 rows -> sad_out = 0, sad_idx = 0, best_sad = 0, best_valid = 1; sad_valid is a single pulse 2 edges after row 16.
- Max difference: spr = 255, cpr = 0 for every pixel of a 16×16 block -> sad_out = 65280. Swapped operands give the same value.
- Three back-to-back blocks, uniform per-pixel differences 3, 1, 1 -> sad_out 768, 256, 256 on idx 0, 1, 2. best_sad = 256 and best_idx = 1 (tie keeps the earlier candidate).
- Random in_valid gaps inside a block with random pixels -> sad_out matches the reference model; sad_valid arrives 2 edges after the 16th valid row.
- clear asserted after row 7, with a row on in_valid in the same cycle -> that row is dropped. The next 16 rows form candidate 0 with a correct SAD, and best_valid is 0 until that block completes.
- rst_n pulsed low mid-block -> all outputs return to reset values immediately (best_sad = all-ones); the next full block yields the correct SAD with idx 0.
